frsim_step_ctrl: RTL and testbench

- Cycle-budget run controller for FrSim co-simulation testbenches.
- The host side (VPI system task glue) issues RUN/PAUSE/RESUME/ABORT commands. The block emits a divided simulation-step enable (tick) and a toggling phase signal (divide-by-2 of tick) to the DUT datapath.
- It counts steps down to zero, then signals completion back to the host.
- It replaces free-running `forever` clocking with host-sequenced stepping.

---
 rtl/frsim_step_ctrl.sv | 147 ++++++++++++++
 tb/tb_frsim_step_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frsim_step_ctrl.sv
// frsim_step_ctrl: host-sequenced step controller for co-simulation.
// It accepts RUN/PAUSE/RESUME/ABORT commands and emits a divided step
// enable (tick), a phase toggle, and a completion pulse with an abort flag.
// Optional lifetime tick counter: define FRSIM_STEP_STATS_EN to build it.
module frsim_step_ctrl #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cycles,
    input  logic [DIV_W-1:0] div_ratio,
    output logic             tick,
    output logic             phase,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             cmd_err,
    output logic [CNT_W-1:0] cycles_left,
    output logic [31:0]      total_ticks
);

    localparam logic [1:0] OP_RUN    = 2'd0;
    localparam logic [1:0] OP_PAUSE  = 2'd1;
    localparam logic [1:0] OP_RESUME = 2'd2;
    localparam logic [1:0] OP_ABORT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] ratio;
    logic             finishing;
    logic             halt_req;
    logic             tick_now;

    // In RUN, cycles_left==0 means the last tick has just been emitted, so the
    // following clock is spent retiring the run. A PAUSE or ABORT taking effect
    // at an edge suppresses any tick that edge would otherwise produce.
    assign finishing = (state == S_RUN) && (cycles_left == '0);
    assign halt_req  = cmd_valid && ((cmd_op == OP_PAUSE) || (cmd_op == OP_ABORT));
    assign tick_now  = (state == S_RUN) && !finishing && !halt_req && (div_cnt == ratio);

    // Command decode, divider, step countdown and all registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            ratio       <= '0;
            tick        <= 1'b0;
            phase       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            cmd_err     <= 1'b0;
            cycles_left <= '0;
        end else begin
            tick    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            cmd_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op == OP_RUN) begin
                            if (cmd_cycles != '0) begin
                                cycles_left <= cmd_cycles;
                                ratio       <= div_ratio;
                                div_cnt     <= '0;
                                state       <= S_RUN;
                                busy        <= 1'b1;
                            end else begin
                                done <= 1'b1;
                            end
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (finishing) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (cmd_valid && (cmd_op == OP_PAUSE)) begin
                        state <= S_PAUSED;
                    end else if (cmd_valid && (cmd_op == OP_ABORT)) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else begin
                        if (cmd_valid) begin
                            cmd_err <= 1'b1;
                        end
                        if (tick_now) begin
                            div_cnt     <= '0;
                            tick        <= 1'b1;
                            phase       <= ~phase;
                            cycles_left <= cycles_left - CNT_W'(1);
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                end
                S_PAUSED: begin
                    if (cmd_valid) begin
                        if (cmd_op == OP_RESUME) begin
                            state <= S_RUN;
                        end else if (cmd_op == OP_ABORT) begin
                            state   <= S_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            aborted <= 1'b1;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FRSIM_STEP_STATS_EN
    // Lifetime tick counter, aligned with tick and saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_ticks <= '0;
        end else if (tick_now && (total_ticks != 32'hFFFF_FFFF)) begin
            total_ticks <= total_ticks + 32'd1;
        end
    end
`else
    assign total_ticks = '0;
`endif

endmodule

// File: tb/tb_frsim_step_ctrl.sv
// Testbench for frsim_step_ctrl: directed command sequences, a cycle-level
// behavioural model compared every clock, plus hand-computed literal checks.
module tb_frsim_step_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_cycles;
    logic [3:0]  div_ratio;
    logic        tick;
    logic        phase;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        cmd_err;
    logic [15:0] cycles_left;
    logic [31:0] total_ticks;

    int vectors = 0;
    int fails   = 0;

    frsim_step_ctrl #(.CNT_W(16), .DIV_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_cycles  (cmd_cycles),
        .div_ratio   (div_ratio),
        .tick        (tick),
        .phase       (phase),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .cmd_err     (cmd_err),
        .cycles_left (cycles_left),
        .total_ticks (total_ticks)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FRSIM_STEP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Behavioural model: mode 0=idle, 1=running, 2=paused; wait_clks counts
    // clocks remaining until the next tick.
    int          m_mode = 0;
    int          m_wait = 0;
    int          m_ratio = 0;
    bit          m_fin = 1'b0;
    logic [15:0] m_left = '0;
    logic        m_phase = 1'b0;
    logic [31:0] m_total = '0;
    logic        e_tick = 1'b0;
    logic        e_done = 1'b0;
    logic        e_ab = 1'b0;
    logic        e_err = 1'b0;

    task automatic model_step();
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
            e_tick  = 1'b1;
            m_left  = m_left - 16'd1;
            m_phase = ~m_phase;
            if (STATS && (m_total != 32'hFFFF_FFFF)) m_total = m_total + 32'd1;
            m_wait = m_ratio + 1;
            if (m_left == 16'd0) m_fin = 1'b1;
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    always @(posedge clk or negedge rst_n) begin
        e_tick = 1'b0;
        e_done = 1'b0;
        e_ab   = 1'b0;
        e_err  = 1'b0;
        if (!rst_n) begin
            m_mode  = 0;
            m_wait  = 0;
            m_ratio = 0;
            m_fin   = 1'b0;
            m_left  = '0;
            m_phase = 1'b0;
            m_total = '0;
        end else if (m_mode == 1 && m_fin) begin
            m_mode = 0;
            m_fin  = 1'b0;
            e_done = 1'b1;
        end else if (cmd_valid) begin
            case (m_mode)
                0: begin
                    if (cmd_op == 2'd0) begin
                        if (cmd_cycles == 16'd0) begin
                            e_done = 1'b1;
                        end else begin
                            m_mode  = 1;
                            m_left  = cmd_cycles;
                            m_ratio = int'(div_ratio);
                            m_wait  = m_ratio + 1;
                        end
                    end else begin
                        e_err = 1'b1;
                    end
                end
                1: begin
                    if (cmd_op == 2'd1) begin
                        m_mode = 2;
                    end else if (cmd_op == 2'd3) begin
                        m_mode = 0;
                        e_done = 1'b1;
                        e_ab   = 1'b1;
                    end else begin
                        e_err = 1'b1;
                        model_step();
                    end
                end
                default: begin
                    if (cmd_op == 2'd2) begin
                        m_mode = 1;
                    end else if (cmd_op == 2'd3) begin
                        m_mode = 0;
                        e_done = 1'b1;
                        e_ab   = 1'b1;
                    end else begin
                        e_err = 1'b1;
                    end
                end
            endcase
        end else if (m_mode == 1) begin
            model_step();
        end
    end

    // Compare every DUT output against the model shortly after each edge.
    always @(posedge clk) begin
        #1;
        vectors++;
        if (tick !== e_tick || phase !== m_phase || busy !== (m_mode != 0) ||
            done !== e_done || aborted !== e_ab || cmd_err !== e_err ||
            cycles_left !== m_left || total_ticks !== m_total) begin
            fails++;
            $display("[TB] FAIL model_compare t=%0t got tick=%b phase=%b busy=%b done=%b ab=%b err=%b left=%0d total=%0d expected tick=%b phase=%b busy=%b done=%b ab=%b err=%b left=%0d total=%0d",
                     $time, tick, phase, busy, done, aborted, cmd_err, cycles_left, total_ticks,
                     e_tick, m_phase, (m_mode != 0), e_done, e_ab, e_err, m_left, m_total);
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Call at a negedge; the command is taken at the next posedge and the task
    // returns at the negedge right after that acceptance edge.
    task automatic apply_stimulus(input logic [1:0] op, input logic [15:0] cyc, input logic [3:0] ratio);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_cycles = cyc;
        div_ratio  = ratio;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n_ticks;
        bit saw_done;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'd0;
        cmd_cycles = '0;
        div_ratio = '0;
        repeat (3) @(negedge clk);
        check_output("reset_flags", {26'd0, tick, phase, busy, done, aborted, cmd_err}, 32'd0);
        check_output("reset_left", {16'd0, cycles_left}, 32'd0);
        check_output("reset_total", total_ticks, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // RUN 5, div 0: five back-to-back ticks, then done.
        apply_stimulus(2'd0, 16'd5, 4'd0);
        check_output("div0_busy", {31'd0, busy}, 32'd1);
        check_output("div0_notick_at_accept", {31'd0, tick}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check_output("div0_tick", {31'd0, tick}, 32'd1);
            check_output("div0_left", {16'd0, cycles_left}, 32'(5 - i));
        end
        @(negedge clk);
        check_output("div0_done", {29'd0, done, aborted, busy}, 32'b100);
        check_output("div0_phase", {31'd0, phase}, 32'd1);
        repeat (2) @(negedge clk);

        // RUN 3, div 3: ticks at clocks 4, 8, 12; done at 13. div_ratio changes ignored.
        apply_stimulus(2'd0, 16'd3, 4'd3);
        div_ratio = 4'd0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 3) check_output("div3_notick_k3", {31'd0, tick}, 32'd0);
            if (k == 4) check_output("div3_tick4", {15'd0, tick, cycles_left}, {15'd0, 1'b1, 16'd2});
            if (k == 8) check_output("div3_tick8", {15'd0, tick, cycles_left}, {15'd0, 1'b1, 16'd1});
            if (k == 12) check_output("div3_tick12", {15'd0, tick, cycles_left}, {15'd0, 1'b1, 16'd0});
            if (k == 13) check_output("div3_done13", {30'd0, done, busy}, 32'b10);
        end
        repeat (2) @(negedge clk);

        // RUN 10, div 1: pause after 4 ticks, hold 20 clocks, resume.
        apply_stimulus(2'd0, 16'd10, 4'd1);
        repeat (8) @(negedge clk);
        check_output("pause_left_before", {16'd0, cycles_left}, 32'd6);
        apply_stimulus(2'd1, 16'd0, 4'd1);
        n_ticks = 0;
        repeat (20) begin
            @(negedge clk);
            if (tick) n_ticks++;
        end
        check_output("paused_ticks", n_ticks, 32'd0);
        check_output("paused_left", {16'd0, cycles_left}, 32'd6);
        check_output("paused_busy", {31'd0, busy}, 32'd1);
        apply_stimulus(2'd2, 16'd0, 4'd1);
        n_ticks = 0;
        saw_done = 1'b0;
        for (int k = 0; k < 60 && !saw_done; k++) begin
            @(negedge clk);
            if (tick) n_ticks++;
            if (done) saw_done = 1'b1;
        end
        check_output("resume_ticks", n_ticks, 32'd6);
        check_output("resume_done", {31'd0, saw_done}, 32'd1);
        repeat (2) @(negedge clk);

        // RUN 8, div 2: abort after 2 ticks, then illegal commands.
        apply_stimulus(2'd0, 16'd8, 4'd2);
        repeat (6) @(negedge clk);
        apply_stimulus(2'd3, 16'd0, 4'd0);
        check_output("abort_flags", {29'd0, done, aborted, busy}, 32'b110);
        check_output("abort_left", {16'd0, cycles_left}, 32'd6);
        @(negedge clk);
        apply_stimulus(2'd2, 16'd0, 4'd0);
        check_output("resume_idle_err", {30'd0, cmd_err, done}, 32'b10);
        @(negedge clk);
        apply_stimulus(2'd0, 16'd8, 4'd2);
        apply_stimulus(2'd0, 16'd20, 4'd0);
        check_output("run_busy_err", {31'd0, cmd_err}, 32'd1);
        check_output("run_busy_left", {16'd0, cycles_left}, 32'd8);
        apply_stimulus(2'd3, 16'd0, 4'd0);
        repeat (2) @(negedge clk);

        // Zero budget, then reset in the middle of a run.
        apply_stimulus(2'd0, 16'd0, 4'd0);
        check_output("zero_done", {28'd0, done, aborted, tick, busy}, 32'b1000);
        @(negedge clk);
        check_output("zero_done_pulse", {31'd0, done}, 32'd0);
        apply_stimulus(2'd0, 16'd100, 4'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("reset_mid_flags", {26'd0, tick, phase, busy, done, aborted, cmd_err}, 32'd0);
        check_output("reset_mid_left", {16'd0, cycles_left}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check_output("reset_no_done", {31'd0, saw_done}, 32'd0);

        // Statistics: RUN 5 complete, RUN 7 aborted after 3 ticks.
        apply_stimulus(2'd0, 16'd5, 4'd0);
        repeat (6) @(negedge clk);
        check_output("stats_run5_done", {31'd0, done}, 32'd1);
        apply_stimulus(2'd0, 16'd7, 4'd0);
        repeat (3) @(negedge clk);
        apply_stimulus(2'd3, 16'd0, 4'd0);
        check_output("stats_abort_left", {16'd0, cycles_left}, 32'd4);
        check_output("stats_total", total_ticks, STATS ? 32'd8 : 32'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
